// File: rtl/stim_seq_pkg.sv
// Shared state encoding and helpers for the stimulus vector sequencer.
package stim_seq_pkg;

  localparam int SETTLE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CAPTURE,
    DONE
  } seq_state_t;

  // Highest vector value for an n_width-bit sweep.
  function automatic int unsigned last_vec(input int unsigned n_width);
    return (32'd1 << n_width) - 32'd1;
  endfunction

endpackage

// File: rtl/stim_settle_timer.sv
// Loadable down-counter that flags the final cycle of a settle interval.
module stim_settle_timer
  import stim_seq_pkg::*;
(
  input  logic                CK,
  input  logic                reset,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                expire
);

  logic [SETTLE_W-1:0] cnt_reg;
  logic [SETTLE_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - SETTLE_W'(1);
    end
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // A zero load expires at once instead of stalling the sweep forever.
  assign expire = (cnt_reg <= SETTLE_W'(1));

endmodule

// File: rtl/stim_vector_sequencer.sv
// Exhaustive stimulus sequencer: sweeps N_out over every vector, waits a settle
// time, then offers {vector, response} records on a valid/ready port.
module stim_vector_sequencer
  import stim_seq_pkg::*;
#(
  parameter int N_WIDTH       = 3,
  parameter int OUT_WIDTH     = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_WIDTH-1:0]   N_out,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_vector,
  output logic [OUT_WIDTH-1:0] rec_response,
  output logic                 busy,
  output logic                 done
);

  localparam int                  CNT_W       = N_WIDTH + 1;
  localparam logic [N_WIDTH-1:0]  LAST_VEC    = N_WIDTH'(last_vec(N_WIDTH));
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  seq_state_t           state_reg, state_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [N_WIDTH-1:0]   n_out_reg, n_out_next;
  logic                 rec_valid_reg, rec_valid_next;
  logic [N_WIDTH-1:0]   rec_vector_reg, rec_vector_next;
  logic [OUT_WIDTH-1:0] rec_response_reg, rec_response_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  logic timer_load;
  logic timer_dec;
  logic timer_expire;
  logic last_hit;

  stim_settle_timer u_settle_timer (
    .CK       (CK),
    .reset    (reset),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .expire   (timer_expire)
  );

  // The spare count bit never sets within a run; it guards the terminal match.
  assign last_hit = !count_reg[N_WIDTH] && (count_reg[N_WIDTH-1:0] == LAST_VEC);

  always_comb begin
    state_next        = state_reg;
    count_next        = count_reg;
    n_out_next        = n_out_reg;
    rec_valid_next    = rec_valid_reg;
    rec_vector_next   = rec_vector_reg;
    rec_response_next = rec_response_reg;
    done_next         = done_reg;
    timer_load        = 1'b0;
    timer_dec         = 1'b0;

    if (abort) begin
      state_next     = IDLE;
      rec_valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_next = APPLY;
            count_next = '0;
            n_out_next = '0;
            done_next  = 1'b0;
          end
        end
        APPLY: begin
          timer_load = 1'b1;
          state_next = SETTLE;
        end
        SETTLE: begin
          timer_dec = 1'b1;
          if (timer_expire) begin
            state_next        = CAPTURE;
            rec_response_next = dut_out;
            rec_vector_next   = count_reg[N_WIDTH-1:0];
            rec_valid_next    = 1'b1;
          end
        end
        CAPTURE: begin
          if (rec_ready) begin
            rec_valid_next = 1'b0;
            if (last_hit) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              count_next = count_reg + CNT_W'(1);
              n_out_next = count_next[N_WIDTH-1:0];
              state_next = APPLY;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    busy_next = (state_next == APPLY) || (state_next == SETTLE) || (state_next == CAPTURE);
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      n_out_reg        <= '0;
      rec_valid_reg    <= 1'b0;
      rec_vector_reg   <= '0;
      rec_response_reg <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      n_out_reg        <= n_out_next;
      rec_valid_reg    <= rec_valid_next;
      rec_vector_reg   <= rec_vector_next;
      rec_response_reg <= rec_response_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
    end
  end

  assign N_out        = n_out_reg;
  assign rec_valid    = rec_valid_reg;
  assign rec_vector   = rec_vector_reg;
  assign rec_response = rec_response_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_stim_vector_sequencer.sv
// Scoreboard bench for stim_vector_sequencer: default instance plus a
// SETTLE_CYCLES=3 / N_WIDTH=2 instance, random responses and back-pressure.
`timescale 1ns/1ps
module tb_stim_vector_sequencer;

  localparam int N1 = 3;
  localparam int S1 = 1;
  localparam int N2 = 2;
  localparam int S2 = 3;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic          reset, start, abort, rec_ready;
  logic [N1-1:0] N_out, rec_vector;
  logic [0:0]    dut_out, rec_response;
  logic          rec_valid, busy, done;

  logic          start2, abort2, rec_ready2;
  logic [N2-1:0] N_out2, rec_vector2;
  logic [0:0]    dut_out2, rec_response2;
  logic          rec_valid2, busy2, done2;

  logic       use_parity;
  logic [7:0] lut_bits;
  logic [3:0] lut2_bits;
  logic       rnd_ready, ready_force;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int exp_q[$];
  int exp_q2[$];
  int par_tab[8] = '{0, 1, 1, 0, 1, 0, 0, 1};

  assign dut_out    = use_parity ? (^N_out) : lut_bits[N_out];
  assign dut_out2   = lut2_bits[N_out2];
  assign abort2     = 1'b0;
  assign rec_ready2 = 1'b1;

  stim_vector_sequencer #(.N_WIDTH(N1), .OUT_WIDTH(1), .SETTLE_CYCLES(S1)) u_dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .N_out(N_out),
    .dut_out(dut_out), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_vector(rec_vector), .rec_response(rec_response), .busy(busy), .done(done)
  );

  stim_vector_sequencer #(.N_WIDTH(N2), .OUT_WIDTH(1), .SETTLE_CYCLES(S2)) u_dut2 (
    .CK(CK), .reset(reset), .start(start2), .abort(abort2), .N_out(N_out2),
    .dut_out(dut_out2), .rec_valid(rec_valid2), .rec_ready(rec_ready2),
    .rec_vector(rec_vector2), .rec_response(rec_response2), .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int enc(input int v, input int r);
    return v * 256 + r;
  endfunction

  // Edge counter; after edge t0+m a negedge sees cyc == t0 + m.
  initial forever begin
    @(posedge CK);
    cyc++;
  end

  // Sole driver of rec_ready: random back-pressure or a forced level.
  initial forever begin
    @(posedge CK);
    #2;
    rec_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Monitor for the default instance: pops on every accepted record and checks
  // that an offered but unaccepted record stays frozen.
  initial begin : mon1
    logic        hold;
    logic [31:0] held;
    int          e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge CK);
      if (!reset) begin
        hold = 1'b0;
      end else begin
        if (hold) check("hold_stable", 32'({rec_valid, rec_vector, rec_response}), held);
        if (rec_valid && rec_ready && !abort) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_record: got vector %0d response %0d, expected none",
                     rec_vector, rec_response);
          end else begin
            e = exp_q.pop_front();
            check("record", 32'(enc(int'(rec_vector), int'(rec_response))), 32'(e));
          end
        end
        hold = rec_valid && !rec_ready && !abort;
        held = 32'({rec_valid, rec_vector, rec_response});
      end
    end
  end

  initial begin : mon2
    int e;
    forever begin
      @(negedge CK);
      if (reset && rec_valid2) begin
        if (exp_q2.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_record2: got vector %0d, expected none", rec_vector2);
        end else begin
          e = exp_q2.pop_front();
          check("record2", 32'(enc(int'(rec_vector2), int'(rec_response2))), 32'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns at the first negedge where the chosen condition holds.
  task automatic wait_for(input int which, input int val, input int bound, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CK);
      case (which)
        0:       hit = (int'(N_out) == val);
        1:       hit = rec_valid;
        2:       hit = done;
        3:       hit = done2;
        default: hit = rec_valid2;
      endcase
      if (hit) break;
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: got no event in %0d cycles, expected one", name, bound);
    end
  endtask

  task automatic start_run(output int t0);
    @(posedge CK);
    #1 start = 1'b1;
    @(posedge CK);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  // Reference model: a sweep yields every vector once, in order, with f(v).
  task automatic push_sweep();
    for (int v = 0; v < (1 << N1); v++)
      exp_q.push_back(enc(v, use_parity ? par_tab[v] : int'(lut_bits[v])));
  endtask

  initial begin
    int t0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    use_parity = 1'b1; lut_bits = '0; lut2_bits = '0;
    rnd_ready = 1'b0; ready_force = 1'b1; rec_ready = 1'b1;

    repeat (3) @(negedge CK);
    check("rst_nout", 32'(N_out), 0);
    check("rst_valid", 32'(rec_valid), 0);
    check("rst_vector", 32'(rec_vector), 0);
    check("rst_response", 32'(rec_response), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    #2 reset = 1'b1;

    // Parity response, sink always ready; a value that first shows after edge
    // t0+m is "at t0+(m+1)", i.e. it is seen within cycle t0+m+1.
    push_sweep();
    start_run(t0);
    @(negedge CK);
    check("busy_t0p1", 32'(busy), 1);
    check("nout_t0p1", 32'(N_out), 0);
    wait_for(1, 0, 20, "first_valid");
    check("first_valid_cycle", 32'(cyc - t0 + 1), 32'(2 + S1));
    wait_for(2, 0, 100, "done1");
    check("done_cycle", 32'(cyc - t0 + 1), 32'((1 << N1) * (2 + S1) + 1));
    check("busy_in_done", 32'(busy), 0);
    check("nout_hold_last", 32'(N_out), 7);
    check("queue_empty_run1", 32'(exp_q.size()), 0);

    // Back-pressure on vector 3.
    use_parity = 1'b0;
    lut_bits   = 8'($urandom);
    push_sweep();
    start_run(t0);
    wait_for(0, 3, 40, "reach3");
    @(posedge CK);
    #1 ready_force = 1'b0;
    wait_for(1, 0, 10, "valid3");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge CK);
      check("bp_valid", 32'(rec_valid), 1);
      check("bp_vector", 32'(rec_vector), 3);
    end
    @(posedge CK);
    #1 ready_force = 1'b1;
    @(posedge CK);
    @(negedge CK);
    check("apply4_nout", 32'(N_out), 4);
    check("apply4_valid", 32'(rec_valid), 0);
    check("apply4_busy", 32'(busy), 1);
    wait_for(2, 0, 100, "done2run");
    check("queue_empty_run2", 32'(exp_q.size()), 0);

    // Abort in SETTLE of vector 5; records 5..7 are never delivered.
    lut_bits = 8'($urandom);
    push_sweep();
    start_run(t0);
    wait_for(0, 5, 60, "reach5");
    @(posedge CK);
    #1 abort = 1'b1;
    @(posedge CK);
    #1 abort = 1'b0;
    @(negedge CK);
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(rec_valid), 0);
    check("abort_done", 32'(done), 0);
    check("abort_undelivered", 32'(exp_q.size()), 3);
    exp_q.delete();
    repeat (3) @(negedge CK);
    check("abort_stays_idle", 32'({busy, rec_valid}), 0);

    // Restart from 0, then two more sweeps, all with random back-pressure.
    rnd_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      lut_bits = 8'($urandom);
      push_sweep();
      start_run(t0);
      wait_for(2, 0, 600, "done_rand");
      check("queue_empty_rand", 32'(exp_q.size()), 0);
    end
    rnd_ready = 1'b0;

    // Asynchronous reset while a record is held in CAPTURE.
    ready_force = 1'b0;
    lut_bits = 8'($urandom);
    push_sweep();
    start_run(t0);
    wait_for(1, 0, 20, "valid_before_reset");
    #2 reset = 1'b0;
    #1;
    check("arst_outputs", 32'({N_out, rec_valid, rec_vector, rec_response, busy, done}), 0);
    @(negedge CK);
    #2 reset = 1'b1;
    exp_q.delete();
    ready_force = 1'b1;
    repeat (2) @(negedge CK);
    check("after_reset_idle", 32'({busy, done, rec_valid}), 0);

    // start while busy is ignored; start+abort from DONE stays out of the run.
    lut_bits = 8'($urandom);
    push_sweep();
    start_run(t0);
    wait_for(0, 2, 40, "reach2");
    @(posedge CK);
    #1 start = 1'b1;
    @(posedge CK);
    #1 start = 1'b0;
    @(negedge CK);
    check("start_busy_nout", 32'(N_out), 2);
    check("start_busy_busy", 32'(busy), 1);
    wait_for(2, 0, 100, "done_run5");
    check("queue_empty_run5", 32'(exp_q.size()), 0);
    @(posedge CK);
    #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge CK);
    #1 begin start = 1'b0; abort = 1'b0; end
    repeat (4) @(negedge CK);
    check("startabort_busy", 32'(busy), 0);
    check("startabort_done", 32'(done), 1);
    check("startabort_valid", 32'(rec_valid), 0);

    // Second instance: 4 vectors, 5 cycles each.
    lut2_bits = 4'($urandom);
    for (int v = 0; v < (1 << N2); v++) exp_q2.push_back(enc(v, int'(lut2_bits[v])));
    @(posedge CK);
    #1 start2 = 1'b1;
    @(posedge CK);
    #1;
    t0     = cyc;
    start2 = 1'b0;
    wait_for(4, 0, 20, "first_valid2");
    check("first_valid2_cycle", 32'(cyc - t0 + 1), 32'(2 + S2));
    wait_for(3, 0, 60, "done_inst2");
    check("done2_cycle", 32'(cyc - t0 + 1), 32'((1 << N2) * (2 + S2) + 1));
    check("queue_empty_inst2", 32'(exp_q2.size()), 0);
    check("busy2_in_done", 32'(busy2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
